// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer with start/data/parity/stop framing
//
// Purpose: takes one character at a time from a TDR/FIFO and shifts it out
// LSB first on txd. The frame is a start bit, 5..8 data bits, an optional
// parity bit, and 1 or 2 stop bits. Bit timing comes from counting baud_tick
// pulses: each bit lasts OVERSAMPLE pulses.
//
// Optional feature: define UART_TX_BREAK_EN to compile break support. When it
// is compiled in, lcr_brk=1 forces txd low.
//
// Ports:
//   clk       - sole clock, rising edge
//   reset_n   - synchronous active-low reset; aborts any frame in flight
//   baud_tick - one-clk pulse at OVERSAMPLE x baud rate
//   tx_data   - character to send (upper bits ignored for short words)
//   tx_valid  - tx_data valid; transfer when tx_valid && tx_ready
//   tx_ready  - high only in IDLE (and not on the reset edge)
//   lcr_wls   - word length 00=5 .. 11=8 bits
//   lcr_stb   - 0=1 stop bit, 1=2 stop bits
//   lcr_pen   - parity enable
//   lcr_eps   - 1=even parity, 0=odd parity
//   lcr_brk   - break control (only with UART_TX_BREAK_EN)
//   txd       - registered serial line, idle high
//   tx_busy   - high from accept until the last stop bit ends
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [1:0] lcr_wls,
  input  logic       lcr_stb,
  input  logic       lcr_pen,
  input  logic       lcr_eps,
  input  logic       lcr_brk,
  output logic       txd,
  output logic       tx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] tick_cnt_d;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_d;
  logic             stop_idx;
  logic             stop_idx_d;
  logic [7:0]       shreg;
  logic [7:0]       shreg_d;

  // Frame format captured at transfer so LCR writes cannot disturb the
  // character in flight.
  logic [2:0]       last_bit_q;
  logic             stb_q;
  logic             pen_q;
  logic             par_q;

  logic             txd_d;
  logic             busy_d;
  logic             ready_d;

  logic             transfer;
  logic             bit_end;
  logic [7:0]       data_mask;
  logic             par_calc;

  assign transfer  = tx_valid && tx_ready;
  assign bit_end   = baud_tick && (tick_cnt == TICK_LAST);
  assign data_mask = 8'hFF >> (2'd3 - lcr_wls);
  // Even parity is the plain XOR of the used data bits; odd inverts it.
  assign par_calc  = (^(tx_data & data_mask)) ^ ~lcr_eps;

`ifndef UART_TX_BREAK_EN
  logic unused_brk;
  assign unused_brk = lcr_brk;
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      state    <= next_state;
      tick_cnt <= tick_cnt_d;
      bit_idx  <= bit_idx_d;
      stop_idx <= stop_idx_d;
      shreg    <= shreg_d;
      txd      <= txd_d;
      tx_busy  <= busy_d;
      tx_ready <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_bit_q <= '0;
      stb_q      <= 1'b0;
      pen_q      <= 1'b0;
      par_q      <= 1'b0;
    end else if (transfer) begin
      last_bit_q <= 3'd4 + {1'b0, lcr_wls};
      stb_q      <= lcr_stb;
      pen_q      <= lcr_pen;
      par_q      <= par_calc;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (transfer) next_state = S_START;
      end
      S_START: begin
        if (bit_end) next_state = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_idx == last_bit_q))
          next_state = pen_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) next_state = S_STOP;
      end
      S_STOP: begin
        if (bit_end && (stop_idx == stb_q)) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Bit timing and shift datapath; counters sit at zero in IDLE so a new
  // frame always starts with a fresh bit period.
  always_comb begin
    tick_cnt_d = tick_cnt;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    shreg_d    = shreg;

    if (state == S_IDLE) begin
      tick_cnt_d = '0;
    end else if (baud_tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt + 1'b1;
    end

    if (state == S_IDLE) begin
      bit_idx_d = '0;
    end else if ((state == S_DATA) && bit_end) begin
      bit_idx_d = bit_idx + 3'd1;
    end

    if (state != S_STOP) begin
      stop_idx_d = 1'b0;
    end else if (bit_end) begin
      stop_idx_d = 1'b1;
    end

    if (transfer) begin
      shreg_d = tx_data;
    end else if ((state == S_DATA) && bit_end) begin
      shreg_d = shreg >> 1;
    end
  end

  // Output logic: values for the registered outputs, derived from the state
  // being entered so txd changes on the same edge as the state.
  always_comb begin
    txd_d = 1'b1;
    case (next_state)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shreg_d[0];
      S_PARITY: txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
`ifdef UART_TX_BREAK_EN
    if (lcr_brk) txd_d = 1'b0;
`endif
    busy_d  = (next_state != S_IDLE);
    ready_d = (next_state == S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

  localparam int OS       = 16;
  localparam int TICK_DIV = 3;
  localparam int TIMEOUT  = 5000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [1:0] lcr_wls = 2'b11;
  logic       lcr_stb = 1'b0;
  logic       lcr_pen = 1'b0;
  logic       lcr_eps = 1'b0;
  logic       lcr_brk = 1'b0;
  logic       txd;
  logic       tx_busy;

  int checks = 0;
  int passes = 0;

  logic exp_q[$];
  logic mon_active = 1'b0;
  int   tick_in_bit = 0;
  int   tick_div = 0;
  int   tick_total = 0;
  int   busy_ticks = 0;

  uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_tick (baud_tick),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .lcr_wls   (lcr_wls),
    .lcr_stb   (lcr_stb),
    .lcr_pen   (lcr_pen),
    .lcr_eps   (lcr_eps),
    .lcr_brk   (lcr_brk),
    .txd       (txd),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  // Baud ticks are generated on the falling edge; the line is sampled at
  // that moment, i.e. during the tick the DUT consumes on the next rising edge.
  always @(negedge clk) begin
    tick_div  = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
    baud_tick = (tick_div == 0);
    if (baud_tick) begin
      tick_total++;
      if (tx_busy === 1'b1) busy_ticks++;
      if (!mon_active && exp_q.size() > 0 && txd === 1'b0) begin
        mon_active  = 1'b1;
        tick_in_bit = 0;
      end
      if (mon_active) begin
        checks++;
        if (txd !== exp_q[0])
          $display("FAIL serial_bit: tick %0d of bit, txd=%b expected %b (t=%0t)", tick_in_bit, txd, exp_q[0], $time);
        else
          passes++;
        tick_in_bit++;
        if (tick_in_bit == OS) begin
          tick_in_bit = 0;
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) mon_active = 1'b0;
        end
      end
    end
  end

  // Reference frame: start, N data bits LSB first, optional parity, stop bit(s).
  task automatic push_frame(input logic [7:0] d, input logic [1:0] wls,
                            input logic pen, input logic eps, input logic stb);
    int n;
    int ones;
    n = 5 + int'(wls);
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) exp_q.push_back(eps ? ones[0] : ~ones[0]);
    exp_q.push_back(1'b1);
    if (stb) exp_q.push_back(1'b1);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL %s_ready_wait: tx_ready=%b expected 1 within %0d clks", name, tx_ready, TIMEOUT);
    else passes++;
  endtask

  // Hands one character over and checks the START entry; afterwards the
  // LCR inputs and data are scrambled to prove they were latched.
  task automatic start_char(input string name, input logic [7:0] d, input logic [1:0] wls,
                            input logic pen, input logic eps, input logic stb, input logic push);
    wait_ready(name);
    busy_ticks = 0;
    tx_data  = d;
    lcr_wls  = wls;
    lcr_pen  = pen;
    lcr_eps  = eps;
    lcr_stb  = stb;
    tx_valid = 1'b1;
    if (push) push_frame(d, wls, pen, eps, stb);
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0 || tx_busy !== 1'b1 || txd !== 1'b0)
      $display("FAIL %s_start: ready/busy/txd=%b%b%b expected 010", name, tx_ready, tx_busy, txd);
    else passes++;
    tx_data = ~d;
    lcr_wls = ~wls;
    lcr_pen = ~pen;
    lcr_eps = ~eps;
    lcr_stb = ~stb;
  endtask

  task automatic wait_drain(input string name, input int exp_busy);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || tx_busy !== 1'b0) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || tx_busy !== 1'b0) begin
      $display("FAIL %s_drain: %0d bits left, tx_busy=%b after %0d clks", name, exp_q.size(), tx_busy, TIMEOUT);
      exp_q.delete();
      mon_active = 1'b0;
    end else passes++;
    checks++;
    if (busy_ticks != exp_busy) $display("FAIL %s_busy_ticks: got %0d expected %0d", name, busy_ticks, exp_busy);
    else passes++;
    checks++;
    if (txd !== 1'b1 || tx_ready !== 1'b1)
      $display("FAIL %s_idle: txd/ready=%b%b expected 11", name, txd, tx_ready);
    else passes++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b0)
      $display("FAIL reset_state: txd/busy/ready=%b%b%b expected 100", txd, tx_busy, tx_ready);
    else passes++;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || txd !== 1'b1)
      $display("FAIL reset_release: ready/busy/txd=%b%b%b expected 101", tx_ready, tx_busy, txd);
    else passes++;
  endtask

  task automatic test_8n1;
    start_char("8n1", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("8n1", 10 * OS);
  endtask

  task automatic test_7e2;
    start_char("7e2", 8'h41, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_drain("7e2", 11 * OS);
  endtask

  task automatic test_5o1;
    start_char("5o1", 8'hFF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain("5o1", 8 * OS);
  endtask

  task automatic test_6e1;
    start_char("6e1", 8'hF3, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_drain("6e1", 9 * OS);
  endtask

  task automatic test_back_to_back;
    int n;
    wait_ready("b2b");
    busy_ticks = 0;
    tx_data  = 8'h55;
    lcr_wls  = 2'b11;
    lcr_pen  = 1'b0;
    lcr_eps  = 1'b0;
    lcr_stb  = 1'b0;
    tx_valid = 1'b1;
    push_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tx_data = 8'hAA;
    push_frame(8'hAA, 2'b11, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_ready !== 1'b1 && n < TIMEOUT);
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL b2b_idle_cycle: tx_ready=%b expected 1", tx_ready);
    else passes++;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0 || tx_busy !== 1'b1 || txd !== 1'b0)
      $display("FAIL b2b_second_start: ready/busy/txd=%b%b%b expected 010", tx_ready, tx_busy, txd);
    else passes++;
    wait_drain("b2b", 20 * OS);
  endtask

  task automatic test_reset_mid_frame;
    int t0;
    int n;
    int bad;
    start_char("rst", 8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    t0 = tick_total;
    n = 0;
    while (tick_total < t0 + OS + 3 * OS + OS / 2 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (txd !== 1'b0 || tx_busy !== 1'b1)
      $display("FAIL rst_mid_data: txd/busy=%b%b expected 01", txd, tx_busy);
    else passes++;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b0)
      $display("FAIL rst_abort: txd/busy/ready=%b%b%b expected 100", txd, tx_busy, tx_ready);
    else passes++;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL rst_ready: tx_ready=%b expected 1", tx_ready);
    else passes++;
    bad = 0;
    repeat (12 * OS * TICK_DIV) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL rst_residual: %0d clks with txd!=1 or busy!=0, expected 0", bad);
    else passes++;
  endtask

  task automatic test_break;
    int t0;
    int n;
    int bad;
    logic exp_stop;
`ifdef UART_TX_BREAK_EN
    exp_stop = 1'b0;
`else
    exp_stop = 1'b1;
`endif
    wait_ready("brk");
    busy_ticks = 0;
    tx_data  = 8'h00;
    lcr_wls  = 2'b11;
    lcr_pen  = 1'b0;
    lcr_eps  = 1'b0;
    lcr_stb  = 1'b0;
    lcr_brk  = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    t0 = tick_total;
    bad = 0;
    n = 0;
    while (tick_total < t0 + 9 * OS + 6 && n < TIMEOUT) begin
      if (tick_total < t0 + 9 * OS - 4 && txd !== 1'b0) bad++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bad != 0) $display("FAIL brk_frame_low: %0d clks with txd=1, expected 0", bad);
    else passes++;
    checks++;
    if (txd !== exp_stop || tx_busy !== 1'b1)
      $display("FAIL brk_in_stop: txd/busy=%b%b expected %b1", txd, tx_busy, exp_stop);
    else passes++;
    lcr_brk = 1'b0;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1) $display("FAIL brk_release: txd=%b expected 1", txd);
    else passes++;
    wait_drain("brk", 10 * OS);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1();
    test_6e1();
    test_back_to_back();
    test_reset_mid_frame();
    test_8n1();
    test_break();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
